// File: rtl/sd_join_pkg.sv
// Shared helpers for the sd_join_atomic join.
//   lane_lsb       : bit offset of lane 'lane' inside a packed join_cnt*width bus.
//   skew_cnt_width : width of the optional skew counter, $clog2(max_skew+1) clamped to 8..32.
package sd_join_pkg;

  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

  function automatic int unsigned skew_cnt_width(input int unsigned max_skew);
    longint unsigned span;
    int unsigned     w;
    // Widen before adding one so max_skew = 2^32-1 does not wrap.
    span = longint'(max_skew) + 64'd1;
    w    = $clog2(span);
    if (w < 8) w = 8;
    if (w > 32) w = 32;
    return w;
  endfunction

endpackage

// File: rtl/sd_join_slot.sv
// One capture slot of the join: a held flag plus a data register.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset (clears held only)
//   capture_en_i   : producer handshake on this lane; loads data_i and sets held
//   release_i      : combined word consumed; clears held unless capturing this cycle
//   data_i         : producer data for this lane
//   held_o         : slot full
//   data_o         : captured data (not reset)
module sd_join_slot #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             capture_en_i,
  input  logic             release_i,
  input  logic [Width-1:0] data_i,
  output logic             held_o,
  output logic [Width-1:0] data_o
);

  logic             held_q, held_d;
  logic [Width-1:0] slot_q;

  // Capture wins over release so a back-to-back word shows no bubble.
  always_comb begin
    held_d = held_q;
    if (capture_en_i) begin
      held_d = 1'b1;
    end else if (release_i) begin
      held_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      held_q <= 1'b0;
    end else begin
      held_q <= held_d;
    end
  end

  // Datapath register left unreset; its contents are meaningless while held_q is low.
  always_ff @(posedge clk_i) begin
    if (capture_en_i) begin
      slot_q <= data_i;
    end
  end

  assign held_o = held_q;
  assign data_o = slot_q;

endmodule

// File: rtl/sd_join_atomic.sv
// sd_join_atomic: collects one item from each of join_cnt srdy/drdy producers and emits them
// as a single combined word. Every lane has a one-entry slot; the output fires only when all
// slots are full and all slots release in the same cycle.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   c_srdy / c_drdy  : per-producer valid / ready (join_cnt bits)
//   c_data           : producer data, lane i at [i*width +: width]
//   p_srdy / p_drdy  : combined word valid / consumer ready
//   p_data           : combined word, lane i holds slot i
//   skew_err         : sticky partial-fill timeout, only with `SD_JOIN_SKEW_CHK_EN defined
// Optional feature macro: SD_JOIN_SKEW_CHK_EN (skew counter + sticky skew_err).
module sd_join_atomic
  import sd_join_pkg::*;
#(
  parameter int unsigned join_cnt = 2,
  parameter int unsigned width    = 32,
  parameter int unsigned max_skew = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [join_cnt-1:0]       c_srdy,
  output logic [join_cnt-1:0]       c_drdy,
  input  logic [join_cnt*width-1:0] c_data,
  output logic                      p_srdy,
  input  logic                      p_drdy,
  output logic [join_cnt*width-1:0] p_data
`ifdef SD_JOIN_SKEW_CHK_EN
  ,
  output logic                      skew_err
`endif
);

  if (join_cnt < 2 || max_skew < 1) begin : g_param_err
    $error("sd_join_atomic: join_cnt must be >= 2 and max_skew >= 1");
  end

  logic [join_cnt-1:0] held;
  logic [join_cnt-1:0] capture_en;
  logic                fire;

  // p_srdy comes straight from the held flops; no path from c_srdy.
  assign p_srdy     = &held;
  assign fire       = p_srdy & p_drdy;
  // A full slot can accept again in the cycle it is released.
  assign c_drdy     = ~held | {join_cnt{fire}};
  assign capture_en = c_srdy & c_drdy;

  for (genvar g = 0; g < join_cnt; g++) begin : g_lane
    sd_join_slot #(
      .Width (width)
    ) u_slot (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .capture_en_i (capture_en[g]),
      .release_i    (fire),
      .data_i       (c_data[lane_lsb(g, width) +: width]),
      .held_o       (held[g]),
      .data_o       (p_data[lane_lsb(g, width) +: width])
    );
  end

`ifdef SD_JOIN_SKEW_CHK_EN
  localparam int unsigned CntW = skew_cnt_width(max_skew);
  localparam logic [CntW-1:0] MaxCnt = CntW'(max_skew);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            partial;

  assign partial = (|held) & ~(&held);

  // Counter runs only while some but not all lanes are held; it saturates at max_skew.
  // The error flag latches on the edge where the counter lands on max_skew.
  always_comb begin
    cnt_d = cnt_q;
    if (!partial) begin
      cnt_d = '0;
    end else if (cnt_q != MaxCnt) begin
      cnt_d = cnt_q + 1'b1;
    end
    err_d = err_q | (cnt_d == MaxCnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign skew_err = err_q;
`endif

endmodule

// File: tb/tb_sd_join_atomic.sv
// Bench for sd_join_atomic: directed table on a 2-lane instance, async reset, streaming,
// a randomized 4-lane run against a queue-based reference model, and (with the macro)
// the skew checker.
module tb_sd_join_atomic;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 2-lane instance
  logic [1:0]     a_c_srdy, a_c_drdy;
  logic [2*W-1:0] a_c_data, a_p_data;
  logic           a_p_srdy, a_p_drdy;
  // 4-lane instance
  logic [3:0]     b_c_srdy, b_c_drdy;
  logic [4*W-1:0] b_c_data, b_p_data;
  logic           b_p_srdy, b_p_drdy;
`ifdef SD_JOIN_SKEW_CHK_EN
  logic a_skew_err, b_skew_err;
`endif

  sd_join_atomic #(.join_cnt(2), .width(W), .max_skew(4)) u_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .c_srdy (a_c_srdy),
    .c_drdy (a_c_drdy),
    .c_data (a_c_data),
    .p_srdy (a_p_srdy),
    .p_drdy (a_p_drdy),
    .p_data (a_p_data)
`ifdef SD_JOIN_SKEW_CHK_EN
    ,
    .skew_err (a_skew_err)
`endif
  );

  sd_join_atomic #(.join_cnt(4), .width(W), .max_skew(255)) u_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .c_srdy (b_c_srdy),
    .c_drdy (b_c_drdy),
    .c_data (b_c_data),
    .p_srdy (b_p_srdy),
    .p_drdy (b_p_drdy),
    .p_data (b_p_data)
`ifdef SD_JOIN_SKEW_CHK_EN
    ,
    .skew_err (b_skew_err)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  srdy;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        pdrdy;
    logic        exp_psrdy;
    logic [1:0]  exp_cdrdy;
    logic [63:0] exp_pdata;
  } vec_t;

  localparam int NTBL = 15;
  vec_t tbl [NTBL];

  task automatic do_reset();
    rst_n = 1'b0;
    a_c_srdy = '0; a_c_data = '0; a_p_drdy = 1'b0;
    b_c_srdy = '0; b_c_data = '0; b_p_drdy = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model for the random run: one FIFO of accepted items per lane.
  logic [31:0] lq [4][$];

  initial begin
    // Skewed arrival, then backpressure, release, then fire+capture without a bubble.
    tbl[0]  = '{2'b01, 32'hAAAA_0000, 32'h0,         1'b0, 1'b0, 2'b11, 64'h0};
    tbl[1]  = '{2'b00, 32'h0,         32'h0,         1'b0, 1'b0, 2'b10, 64'h0};
    tbl[2]  = '{2'b00, 32'h0,         32'h0,         1'b0, 1'b0, 2'b10, 64'h0};
    tbl[3]  = '{2'b10, 32'h0,         32'h0000_BBBB, 1'b0, 1'b0, 2'b10, 64'h0};
    tbl[4]  = '{2'b00, 32'h0,         32'h0,         1'b0, 1'b1, 2'b00, 64'h0000_BBBB_AAAA_0000};
    tbl[5]  = '{2'b00, 32'h0,         32'h0,         1'b0, 1'b1, 2'b00, 64'h0000_BBBB_AAAA_0000};
    tbl[6]  = '{2'b11, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b1, 2'b00, 64'h0000_BBBB_AAAA_0000};
    tbl[7]  = '{2'b00, 32'h0,         32'h0,         1'b0, 1'b1, 2'b00, 64'h0000_BBBB_AAAA_0000};
    tbl[8]  = '{2'b00, 32'h0,         32'h0,         1'b0, 1'b1, 2'b00, 64'h0000_BBBB_AAAA_0000};
    tbl[9]  = '{2'b00, 32'h0,         32'h0,         1'b1, 1'b1, 2'b11, 64'h0000_BBBB_AAAA_0000};
    tbl[10] = '{2'b00, 32'h0,         32'h0,         1'b1, 1'b0, 2'b11, 64'h0};
    tbl[11] = '{2'b11, 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 2'b11, 64'h0};
    tbl[12] = '{2'b11, 32'h0000_0003, 32'h0000_0004, 1'b1, 1'b1, 2'b11, 64'h0000_0002_0000_0001};
    tbl[13] = '{2'b00, 32'h0,         32'h0,         1'b1, 1'b1, 2'b11, 64'h0000_0004_0000_0003};
    tbl[14] = '{2'b00, 32'h0,         32'h0,         1'b0, 1'b0, 2'b11, 64'h0};

    // Reset values, visible while reset is still asserted.
    rst_n = 1'b0;
    a_c_srdy = '0; a_c_data = '0; a_p_drdy = 1'b0;
    b_c_srdy = '0; b_c_data = '0; b_p_drdy = 1'b0;
    #1;
    check("reset p_srdy", a_p_srdy, 1'b0);
    check("reset c_drdy", a_c_drdy, 2'b11);
    check("reset b c_drdy", b_c_drdy, 4'hF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven directed sequence.
    for (int i = 0; i < NTBL; i++) begin
      @(negedge clk);
      a_c_srdy = tbl[i].srdy;
      a_c_data = {tbl[i].d1, tbl[i].d0};
      a_p_drdy = tbl[i].pdrdy;
      #1;
      check($sformatf("tbl[%0d] p_srdy", i), a_p_srdy, tbl[i].exp_psrdy);
      check($sformatf("tbl[%0d] c_drdy", i), a_c_drdy, tbl[i].exp_cdrdy);
      if (tbl[i].exp_psrdy) check($sformatf("tbl[%0d] p_data", i), a_p_data, tbl[i].exp_pdata);
    end

    // Asynchronous reset mid-cycle drops p_srdy without a clock edge.
    @(negedge clk);
    a_c_srdy = 2'b11; a_c_data = {32'h5, 32'h6}; a_p_drdy = 1'b0;
    @(posedge clk);
    #2;
    check("pre-async p_srdy", a_p_srdy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async p_srdy", a_p_srdy, 1'b0);
    check("async c_drdy", a_c_drdy, 2'b11);
    a_c_srdy = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming: 100 words, no bubbles.
    for (int i = 0; i <= 100; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check($sformatf("stream[%0d] p_srdy", i - 1), a_p_srdy, 1'b1);
        check($sformatf("stream[%0d] p_data", i - 1), a_p_data, {32'(i - 1), 32'(i - 1)});
      end
      a_p_drdy = 1'b1;
      if (i < 100) begin
        a_c_srdy = 2'b11;
        a_c_data = {32'(i), 32'(i)};
        #1;
        check($sformatf("stream[%0d] c_drdy", i), a_c_drdy, 2'b11);
      end else begin
        a_c_srdy = 2'b00;
      end
    end
    @(negedge clk);
    check("stream drained", a_p_srdy, 1'b0);
    a_p_drdy = 1'b0;

    // Randomized 4-lane run against the per-lane FIFO model.
    begin
      int          words_out;
      int          cycles;
      logic [3:0]  acc;
      logic [3:0]  exp_drdy;
      logic        exp_psrdy;
      logic        fire;
      logic [127:0] exp_word;
      words_out = 0;
      cycles    = 0;
      acc       = '0;
      for (int l = 0; l < 4; l++) lq[l].delete();
      while (words_out < 10000 && cycles < 60000) begin
        @(negedge clk);
        cycles++;
        for (int l = 0; l < 4; l++) begin
          if (acc[l]) b_c_srdy[l] = 1'b0;
          if (!b_c_srdy[l] && $urandom_range(3) != 0) begin
            b_c_srdy[l] = 1'b1;
            b_c_data[l*W +: W] = $urandom;
          end
        end
        b_p_drdy = ($urandom_range(3) != 0);
        #1;
        exp_psrdy = 1'b1;
        for (int l = 0; l < 4; l++) if (lq[l].size() == 0) exp_psrdy = 1'b0;
        fire = exp_psrdy & b_p_drdy;
        for (int l = 0; l < 4; l++) exp_drdy[l] = (lq[l].size() == 0) | fire;
        check("rnd p_srdy", b_p_srdy, exp_psrdy);
        check("rnd c_drdy", b_c_drdy, exp_drdy);
        if (fire) begin
          for (int l = 0; l < 4; l++) exp_word[l*W +: W] = lq[l].pop_front();
          check($sformatf("rnd word %0d", words_out), b_p_data, exp_word);
          words_out++;
        end
        acc = b_c_srdy & exp_drdy;
        for (int l = 0; l < 4; l++) if (acc[l]) lq[l].push_back(b_c_data[l*W +: W]);
      end
      check("rnd words out", 32'(words_out), 32'd10000);
      @(negedge clk);
      b_c_srdy = '0;
      b_p_drdy = 1'b0;
    end

`ifdef SD_JOIN_SKEW_CHK_EN
    // Skew checker: lane0 held alone; error on the 5th partial cycle, sticky afterwards.
    do_reset();
    @(negedge clk);
    a_c_srdy = 2'b01; a_c_data = {32'h0, 32'hCAFE_0000}; a_p_drdy = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      a_c_srdy = 2'b00;
      #1;
      check($sformatf("skew cycle %0d", k), a_skew_err, (k >= 5));
    end
    @(negedge clk);
    a_c_srdy = 2'b10; a_c_data = {32'hBEEF_0000, 32'h0};
    @(negedge clk);
    a_c_srdy = 2'b00; a_p_drdy = 1'b1;
    #1;
    check("skew join p_srdy", a_p_srdy, 1'b1);
    check("skew join p_data", a_p_data, 64'hBEEF_0000_CAFE_0000);
    @(negedge clk);
    a_p_drdy = 1'b0;
    #1;
    check("skew sticky", a_skew_err, 1'b1);
    check("skew after fire p_srdy", a_p_srdy, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
